// File: rtl/result_sender.sv
// Transmit side of the 8-bit result bus: sends a 16-bit word low byte first,
// then high byte, and holds finala low until the receiver has captured both.
module result_sender #(
  parameter int HOLD_CYCLES   = 1,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] value_in,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  result_data,
  output logic        sl,
  output logic        finala
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_SETTLE,
    S_DONE
  } state_t;

  localparam logic [3:0] HOLD_LAST   = 4'(HOLD_CYCLES - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] latch, latch_nxt;
  logic [7:0]  data_nxt;
  logic        sl_nxt;
  logic        idle_like_nxt;

  always_comb begin
    state_nxt = state;
    latch_nxt = latch;
    cnt_nxt   = cnt + 4'd1;
    case (state)
      S_IDLE, S_DONE: begin
        cnt_nxt = cnt;
        if (start) begin
          latch_nxt = value_in;
          state_nxt = S_LO;
        end
      end
      S_LO:     if (cnt == HOLD_LAST)   state_nxt = S_HI;
      S_HI:     if (cnt == HOLD_LAST)   state_nxt = S_SETTLE;
      S_SETTLE: if (cnt == SETTLE_LAST) state_nxt = S_DONE;
      default:  state_nxt = S_IDLE;
    endcase
    if (state_nxt != state) cnt_nxt = 4'd0;

    // Outputs are registered, so they are derived from the state being entered.
    data_nxt = result_data;
    sl_nxt   = sl;
    case (state_nxt)
      S_LO: begin
        data_nxt = latch_nxt[7:0];
        sl_nxt   = 1'b1;
      end
      S_HI, S_SETTLE: begin
        data_nxt = latch_nxt[15:8];
        sl_nxt   = 1'b0;
      end
      default: ;
    endcase
    idle_like_nxt = (state_nxt == S_IDLE) || (state_nxt == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      latch       <= 16'h0000;
      result_data <= 8'h00;
      sl          <= 1'b1;
      finala      <= 1'b1;
      ready       <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      latch       <= latch_nxt;
      result_data <= data_nxt;
      sl          <= sl_nxt;
      finala      <= idle_like_nxt;
      ready       <= idle_like_nxt;
      busy        <= ~idle_like_nxt;
      done        <= (state_nxt == S_DONE) && (state != S_DONE);
    end
  end

endmodule

// File: tb/tb_result_sender.sv
// Bench for result_sender: two instances (default timing and HOLD=3), a
// cycle-timeline model of each, a receiver model and directed scenarios.
module tb_result_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_v   = 2'b11;
  logic [1:0]       start_v = 2'b00;
  logic [1:0][15:0] value_v = '0;
  logic [1:0]       ready_o, busy_o, done_o, sl_o, fin_o;
  logic [1:0][7:0]  data_o;

  result_sender #(.HOLD_CYCLES(1), .SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .value_in(value_v[0]),
    .ready(ready_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .result_data(data_o[0]), .sl(sl_o[0]), .finala(fin_o[0]));

  result_sender #(.HOLD_CYCLES(3), .SETTLE_CYCLES(2)) dut_b (
    .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .value_in(value_v[1]),
    .ready(ready_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .result_data(data_o[1]), .sl(sl_o[1]), .finala(fin_o[1]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: position t within the transfer timeline (t = cycles since accept).
  int          hp[2] = '{1, 3};
  int          sp[2] = '{2, 2};
  int          t[2]  = '{-1, -1};
  logic [15:0] m_word[2];
  logic [7:0]  e_data[2];
  logic        e_sl[2], e_fin[2], e_ready[2], e_busy[2], e_done[2];
  bit          chk_en = 0;
  int          lim;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      lim = 2 * hp[i] + sp[i];
      if (rst_v[i]) begin
        t[i] = -1; m_word[i] = 16'h0; e_data[i] = 8'h00; e_sl[i] = 1'b1;
      end else if (e_ready[i] && start_v[i]) begin
        m_word[i] = value_v[i]; t[i] = 0;
      end else if (t[i] >= 0 && t[i] <= lim) begin
        t[i]++;
      end
      if (t[i] >= 0 && t[i] < lim) begin
        e_ready[i] = 0; e_busy[i] = 1; e_fin[i] = 0; e_done[i] = 0;
        e_sl[i]   = (t[i] < hp[i]);
        e_data[i] = (t[i] < hp[i]) ? m_word[i][7:0] : m_word[i][15:8];
      end else begin
        e_ready[i] = 1; e_busy[i] = 0; e_fin[i] = 1;
        e_done[i]  = (t[i] == lim);
      end
    end
  end

  // Receiver model and run-length monitors.
  logic [15:0] bin[2];
  int fl_run[2] = '{0, 0}, fl_last[2] = '{0, 0};
  int fh_run[2] = '{0, 0}, fh_last[2] = '{0, 0};
  int done_cnt[2] = '{0, 0};

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("outs%0d", i),
            {24'(data_o[i]), sl_o[i], fin_o[i], ready_o[i], busy_o[i], done_o[i]},
            {24'(e_data[i]), e_sl[i], e_fin[i], e_ready[i], e_busy[i], e_done[i]});
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (!fin_o[i]) begin
        if (sl_o[i]) bin[i][7:0] = data_o[i]; else bin[i][15:8] = data_o[i];
        fl_run[i]++;
        if (fh_run[i] > 0) fh_last[i] = fh_run[i];
        fh_run[i] = 0;
      end else begin
        fh_run[i]++;
        if (fl_run[i] > 0) fl_last[i] = fl_run[i];
        fl_run[i] = 0;
      end
      if (done_o[i]) done_cnt[i]++;
    end
  end

  function automatic logic [15:0] mag(input logic [15:0] v);
    return v[15] ? 16'(-v) : v;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic send(input int i, input logic [15:0] v);
    start_v[i] = 1'b1; value_v[i] = v;
    tick(1);
    start_v[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int max);
    for (int k = 0; k < max; k++) begin
      tick(1);
      if (done_o[i]) return;
    end
    chk($sformatf("done_timeout%0d", i), 32'd0, 32'd1);
  endtask

  task automatic chk_reset_vals(input int i, input string tag);
    chk({tag, "_fin"},   fin_o[i],   1'b1);
    chk({tag, "_sl"},    sl_o[i],    1'b1);
    chk({tag, "_data"},  data_o[i],  8'h00);
    chk({tag, "_ready"}, ready_o[i], 1'b1);
    chk({tag, "_busy"},  busy_o[i],  1'b0);
  endtask

  int d0;

  initial begin
    tick(2);
    rst_v = 2'b00;
    chk_en = 1;
    chk_reset_vals(0, "rst_a");
    chk_reset_vals(1, "rst_b");
    chk("rst_done", done_o[0], 1'b0);

    // Basic send 1234
    send(0, 16'h1234);
    chk("basic_lo_data", data_o[0], 8'h34);
    chk("basic_lo_sl", sl_o[0], 1'b1);
    wait_done(0, 10);
    settle();
    chk("basic_bin", bin[0], 16'h1234);
    chk("basic_fl", fl_last[0], 4);
    chk("basic_ready", ready_o[0], 1'b1);

    // Negative value
    tick(2);
    send(0, 16'hFFF6);
    wait_done(0, 10);
    settle();
    chk("neg_bin", bin[0], 16'hFFF6);
    chk("neg_ans", mag(bin[0]), 16'h000A);

    // Start while busy (in HI phase)
    tick(1);
    d0 = done_cnt[0];
    send(0, 16'h5A3C);
    tick(1);
    send(0, 16'hAAAA);
    wait_done(0, 10);
    settle();
    tick(3);
    chk("busy_bin", bin[0], 16'h5A3C);
    chk("busy_done_cnt", done_cnt[0], d0 + 1);

    // Back-to-back
    send(0, 16'h1111);
    wait_done(0, 10);
    send(0, 16'h00FF);
    chk("b2b_data", data_o[0], 8'hFF);
    chk("b2b_sl", sl_o[0], 1'b1);
    chk("b2b_fin", fin_o[0], 1'b0);
    settle();
    chk("b2b_fh", fh_last[0], 1);
    wait_done(0, 10);
    settle();
    chk("b2b_bin", bin[0], 16'h00FF);

    // Reset mid-transfer, in the second cycle with sl=0
    tick(1);
    d0 = done_cnt[0];
    send(0, 16'h4321);
    tick(2);
    rst_v[0] = 1'b1;
    tick(1);
    rst_v[0] = 1'b0;
    chk_reset_vals(0, "mid");
    tick(6);
    chk("mid_no_done", done_cnt[0], d0);

    // start together with rst: reset wins
    rst_v[0] = 1'b1; start_v[0] = 1'b1; value_v[0] = 16'h7777;
    tick(1);
    rst_v[0] = 1'b0; start_v[0] = 1'b0;
    tick(2);
    chk("rst_start_fin", fin_o[0], 1'b1);
    chk("rst_start_busy", busy_o[0], 1'b0);
    send(0, 16'h0BAD);
    wait_done(0, 10);
    settle();
    chk("after_rst_bin", bin[0], 16'h0BAD);

    // HOLD_CYCLES=3 instance
    send(1, 16'h8001);
    chk("h3_lo_data", data_o[1], 8'h01);
    wait_done(1, 20);
    settle();
    chk("h3_fl", fl_last[1], 8);
    chk("h3_bin", bin[1], 16'h8001);
    chk("h3_ans", mag(bin[1]), 16'h7FFF);
    chk("h3_done_cnt", done_cnt[1], 1);

    tick(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
